// File: rtl/led_serial_tx.sv
// led_serial_tx: serialises a parallel LED pattern into an external chain of
// serial-in/parallel-out shift registers, then pulses the chain's latch.
// The pattern is shifted LSB first, so data[0] ends up at the far end (LED 0).
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset; aborts any frame in progress
//   start    request to send; only looked at while idle
//   data     LED pattern, captured on the edge that accepts start
//   busy     high while a frame is in progress
//   done     one-cycle pulse at frame completion
//   led_clk  shift clock to the chain (chain samples on its rising edge)
//   led_dat  serial data to the chain
//   led_lat  latch strobe, high for CLK_DIV cycles after the last bit
module led_serial_tx #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             led_clk,
    output logic             led_dat,
    output logic             led_lat
);

    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_END  = DW'(CLK_DIV - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SHIFT_LO = 3'd1;
    localparam logic [2:0] SHIFT_HI = 3'd2;
    localparam logic [2:0] LATCH    = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]       state_q, state_d;
    // sr holds the bits not yet presented on led_dat; bit 0 is the next one out.
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             clk_q, clk_d;
    logic             dat_q, dat_d;
    logic             lat_q, lat_d;
    logic             div_tick;

    assign div_tick = (div_q == DIV_END);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        div_d   = div_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        clk_d   = clk_q;
        dat_d   = dat_q;
        lat_d   = lat_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = data >> 1;
                    dat_d   = data[0];
                    bit_d   = '0;
                    div_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_tick) begin
                    div_d   = '0;
                    clk_d   = 1'b1;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            SHIFT_HI: begin
                if (div_tick) begin
                    div_d = '0;
                    clk_d = 1'b0;
                    bit_d = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) begin
                        dat_d   = 1'b0;
                        lat_d   = 1'b1;
                        state_d = LATCH;
                    end else begin
                        // Next bit changes together with the falling led_clk.
                        dat_d   = sr_q[0];
                        sr_d    = sr_q >> 1;
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            LATCH: begin
                if (div_tick) begin
                    div_d   = '0;
                    lat_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DONE: begin
                // start is deliberately ignored here, forcing an idle cycle between frames.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                clk_d   = 1'b0;
                dat_d   = 1'b0;
                lat_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clk_q   <= 1'b0;
            dat_q   <= 1'b0;
            lat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clk_q   <= clk_d;
            dat_q   <= dat_d;
            lat_q   <= lat_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign led_clk = clk_q;
    assign led_dat = dat_q;
    assign led_lat = lat_q;

endmodule

// File: tb/tb_led_serial_tx.sv
// Bench for led_serial_tx: a default 16-bit / CLK_DIV=4 instance and an
// 8-bit / CLK_DIV=1 instance, each observed by a chain model and a scoreboard.
module tb_led_serial_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data = '0;
    logic        busy, done, led_clk, led_dat, led_lat;
    logic        start_b = 1'b0;
    logic [7:0]  data_b = '0;
    logic        busy_b, done_b, led_clk_b, led_dat_b, led_lat_b;

    always #5 clk = ~clk;

    led_serial_tx #(.WIDTH(16), .CLK_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .data(data),
        .busy(busy), .done(done), .led_clk(led_clk), .led_dat(led_dat), .led_lat(led_lat)
    );

    led_serial_tx #(.WIDTH(8), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .data(data_b),
        .busy(busy_b), .done(done_b), .led_clk(led_clk_b), .led_dat(led_dat_b),
        .led_lat(led_lat_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- scoreboard + chain model, instance A ----------------
    logic [15:0] exp_q[$];
    logic [15:0] chain = '0;
    int rises = 0, rises_total = 0, busy_cnt = 0, t0 = 0, last_done = 0;
    int done_cnt = 0, lat_cnt = 0, starts = 0;
    logic prev_clk = 0, prev_lat = 0, prev_busy = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_clk = 0; prev_lat = 0; prev_busy = 0; rises = 0; busy_cnt = 0;
            end else begin
                if (led_clk && !prev_clk) begin
                    if (exp_q.size() > 0 && rises < 16) check("a_bit", led_dat, exp_q[0][rises]);
                    chain = {led_dat, chain[15:1]};
                    rises++;
                    rises_total++;
                end
                if (led_lat && !prev_lat) begin
                    lat_cnt++;
                    check("a_rises", rises, 16);
                    rises = 0;
                    if (exp_q.size() == 0) fail_now("a_unexpected_latch");
                    else check("a_chain", chain, exp_q.pop_front());
                end
                if (busy && !prev_busy) begin t0 = cyc; starts++; end
                if (busy) busy_cnt++;
                if (done) begin
                    done_cnt++;
                    check("a_busy_len", busy_cnt, 132);
                    check("a_done_time", cyc - t0, 132);
                    busy_cnt = 0;
                    last_done = cyc;
                end
                prev_clk = led_clk; prev_lat = led_lat; prev_busy = busy;
            end
        end
    end

    // ---------------- scoreboard + chain model, instance B ----------------
    logic [7:0] exp_qb[$];
    logic [7:0] chain_b = '0;
    int rises_b = 0, busy_cnt_b = 0, t0_b = 0, done_cnt_b = 0;
    logic prev_clk_b = 0, prev_lat_b = 0, prev_busy_b = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_clk_b = 0; prev_lat_b = 0; prev_busy_b = 0; rises_b = 0; busy_cnt_b = 0;
            end else begin
                if (led_clk_b && !prev_clk_b) begin
                    chain_b = {led_dat_b, chain_b[7:1]};
                    rises_b++;
                end
                if (led_lat_b && !prev_lat_b) begin
                    check("b_rises", rises_b, 8);
                    rises_b = 0;
                    if (exp_qb.size() == 0) fail_now("b_unexpected_latch");
                    else check("b_chain", chain_b, exp_qb.pop_front());
                end
                if (busy_b && !prev_busy_b) t0_b = cyc;
                if (busy_b) busy_cnt_b++;
                if (done_b) begin
                    done_cnt_b++;
                    check("b_busy_len", busy_cnt_b, 17);
                    check("b_done_time", cyc - t0_b, 17);
                    busy_cnt_b = 0;
                end
                prev_clk_b = led_clk_b; prev_lat_b = led_lat_b; prev_busy_b = busy_b;
            end
        end
    end

    task automatic wait_done(input bit sel, input int target);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if ((sel ? done_cnt_b : done_cnt) >= target) return;
        end
        fail_now(sel ? "b_done_timeout" : "a_done_timeout");
    endtask

    // One frame; inject > 0 pulses start with 16'hFFFF at T0+inject.
    task automatic send_frame(input bit sel, input logic [15:0] d, input logic [15:0] e,
                              input int inject);
        int dc;
        dc = sel ? done_cnt_b : done_cnt;
        @(negedge clk);
        if (sel) begin start_b = 1; data_b = d[7:0]; exp_qb.push_back(e[7:0]); end
        else begin start = 1; data = d; exp_q.push_back(e); end
        @(negedge clk);
        start = 0; start_b = 0;
        if (inject > 0) begin
            repeat (inject - 1) @(negedge clk);
            start = 1; data = 16'hFFFF;
            @(negedge clk);
            start = 0;
        end
        wait_done(sel, dc + 1);
        repeat (5) @(posedge clk);
        check(sel ? "b_one_done" : "a_one_done", sel ? done_cnt_b : done_cnt, dc + 1);
    endtask

    typedef struct {
        bit          sel;
        logic [15:0] data;
        logic [15:0] exp;
        int          inject;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int dc, lc, rt;
        vecs[0] = '{1'b0, 16'hA5C3, 16'hA5C3, 40};
        vecs[1] = '{1'b0, 16'h0000, 16'h0000, 0};
        vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 0};
        vecs[3] = '{1'b0, 16'h8001, 16'h8001, 0};
        vecs[4] = '{1'b0, 16'h3C5A, 16'h3C5A, 0};
        vecs[5] = '{1'b1, 16'h0081, 16'h0081, 0};
        vecs[6] = '{1'b1, 16'h003C, 16'h003C, 0};

        // Reset state.
        #1;
        check("rst_outputs_a", {busy, done, led_clk, led_dat, led_lat}, 5'b0);
        check("rst_outputs_b", {busy_b, done_b, led_clk_b, led_dat_b, led_lat_b}, 5'b0);
        repeat (2) @(negedge clk);
        rst = 0;

        // Idle with start low: no shift clock activity.
        rt = rises_total;
        repeat (50) @(negedge clk);
        check("idle_no_rises", rises_total, rt);
        check("idle_busy", busy, 1'b0);

        // Table of single frames.
        for (int i = 0; i < 7; i++)
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].exp, vecs[i].inject);

        // Back-to-back with start held high.
        dc = done_cnt;
        lc = starts;
        @(negedge clk);
        start = 1; data = 16'h0001;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h8000);
        @(negedge clk);
        data = 16'h8000;
        wait_done(1'b0, dc + 1);
        for (int i = 0; i < 20 && starts < lc + 2; i++) @(posedge clk);
        @(negedge clk);
        start = 0;
        check("b2b_second_start", starts, lc + 2);
        check("b2b_gap", t0 - last_done, 2);
        wait_done(1'b0, dc + 2);
        repeat (5) @(posedge clk);
        check("b2b_dones", done_cnt, dc + 2);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a frame.
        dc = done_cnt;
        lc = lat_cnt;
        @(negedge clk);
        start = 1; data = 16'h5A5A;
        @(negedge clk);
        start = 0;
        repeat (59) @(negedge clk);
        check("mid_busy_before_rst", busy, 1'b1);
        #1 rst = 1;
        #1;
        check("mid_rst_outputs", {busy, done, led_clk, led_dat, led_lat}, 5'b0);
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (200) @(posedge clk);
        check("mid_no_done", done_cnt, dc);
        check("mid_no_latch", lat_cnt, lc);
        send_frame(1'b0, 16'h1234, 16'h1234, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        fail_now("watchdog");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
